// File: rtl/irq_pkg.sv
// Shared types and helpers for the round-robin interrupt arbiter.
package irq_pkg;

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;

    localparam int MCAUSE_W = 32;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin find-first: lowest set request at or above start,
// wrapping from N-1 back to 0.
module rr_pick #(
    parameter int N    = 32,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] start,
    output logic            vld,
    output logic [ID_W-1:0] idx
);

    localparam logic [ID_W:0] N_W = (ID_W + 1)'(N);

    logic [N-1:0]    rot;
    logic [ID_W-1:0] off;
    logic [ID_W:0]   sum;

    // Rotate so that bit 0 of rot corresponds to req[start].
    assign rot = N'({req, req} >> start);

    always_comb begin
        vld = 1'b0;
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                vld = 1'b1;
                off = ID_W'(i);
            end
        end
    end

    assign sum = {1'b0, start} + {1'b0, off};
    assign idx = (sum >= N_W) ? ID_W'(sum - N_W) : ID_W'(sum);

endmodule

// File: rtl/irq_rr_arbiter.sv
// Round-robin interrupt arbiter with claim/mret handshake toward the trap unit.
module irq_rr_arbiter
    import irq_pkg::*;
#(
    parameter int N_SRC = 32,
    parameter int ID_W  = $clog2(N_SRC)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [N_SRC-1:0]    src_i,
    input  logic [N_SRC-1:0]    edge_en_i,
    input  logic [N_SRC-1:0]    mie_i,
    input  logic                claim_i,
    input  logic                int_rst_i,
    output logic                int_o,
    output logic [ID_W-1:0]     int_id_o,
    output logic [MCAUSE_W-1:0] mcause_o,
    output logic                busy_o,
    output logic [N_SRC-1:0]    pending_o
);

    state_e           state;
    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] pend_edge;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] elig;
    logic [N_SRC-1:0] clr;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  sel_idx;
    logic             sel_vld;
    logic             claim_ok;

    assign rise     = src_i & ~src_q;
    assign pend     = (pend_edge & edge_en_i) | (src_i & ~edge_en_i);
    assign elig     = pend & mie_i;
    assign claim_ok = (state == REQ) && claim_i;
    assign clr      = claim_ok ? (N_SRC'(1) << int_id_o) : '0;

    rr_pick #(
        .N    (N_SRC),
        .ID_W (ID_W)
    ) u_pick (
        .req   (elig),
        .start (rr_ptr),
        .vld   (sel_vld),
        .idx   (sel_idx)
    );

    // A new rise outranks the claim clear landing in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            src_q     <= '0;
            pend_edge <= '0;
        end else begin
            src_q     <= src_i;
            pend_edge <= ((pend_edge & ~clr) | rise) & edge_en_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            int_o    <= 1'b0;
            int_id_o <= '0;
            rr_ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        state    <= REQ;
                        int_o    <= 1'b1;
                        int_id_o <= sel_idx;
                    end
                end
                REQ: begin
                    if (claim_i) begin
                        state  <= SERVICE;
                        int_o  <= 1'b0;
                        rr_ptr <= ID_W'(wrap_inc(int'(int_id_o), N_SRC));
                    end else if (!elig[int_id_o]) begin
                        state <= IDLE;
                        int_o <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (int_rst_i) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    int_o <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o   = (state == SERVICE);
    assign mcause_o = {{(MCAUSE_W - ID_W){1'b0}}, int_id_o};
    // Level lines pass straight through, so mask them while reset is held.
    assign pending_o = rst_i ? '0 : pend;

endmodule

// File: tb/tb_irq_rr_arbiter.sv
// Randomized and directed bench for irq_rr_arbiter against a behavioural model.
module tb_irq_rr_arbiter;

    localparam int N = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  src = '0;
    logic [N-1:0]  edge_en = '0;
    logic [N-1:0]  mie = '0;
    logic          claim = 1'b0;
    logic          int_rst = 1'b0;
    logic          int_o;
    logic [4:0]    int_id;
    logic [31:0]   mcause;
    logic          busy;
    logic [N-1:0]  pending;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    irq_rr_arbiter #(.N_SRC(N)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .src_i     (src),
        .edge_en_i (edge_en),
        .mie_i     (mie),
        .claim_i   (claim),
        .int_rst_i (int_rst),
        .int_o     (int_o),
        .int_id_o  (int_id),
        .mcause_o  (mcause),
        .busy_o    (busy),
        .pending_o (pending)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: pending bits, state (0 idle, 1 presenting, 2 servicing),
    // presented id and the round-robin starting point.
    bit m_pedge[N];
    bit m_srcq[N];
    int m_state, m_id, m_ptr;
    bit m_int;

    always @(posedge clk or posedge rst) begin : model
        bit elig[N];
        bit rise[N];
        bit found;
        int sel, clr_id, j;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_pedge[i] = 0;
                m_srcq[i]  = 0;
            end
            m_state = 0; m_id = 0; m_ptr = 0; m_int = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                rise[i] = src[i] && !m_srcq[i];
                elig[i] = (edge_en[i] ? m_pedge[i] : src[i]) && mie[i];
            end
            found = 0; sel = 0;
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (!found && elig[j]) begin
                    found = 1;
                    sel = j;
                end
            end
            clr_id = -1;
            if (m_state == 0) begin
                if (found) begin
                    m_state = 1; m_int = 1; m_id = sel;
                end
            end else if (m_state == 1) begin
                if (claim) begin
                    m_state = 2; m_int = 0; clr_id = m_id; m_ptr = (m_id + 1) % N;
                end else if (!elig[m_id]) begin
                    m_state = 0; m_int = 0;
                end
            end else begin
                if (int_rst) m_state = 0;
            end
            for (int i = 0; i < N; i++) begin
                m_pedge[i] = ((m_pedge[i] && i != clr_id) || rise[i]) && edge_en[i];
                m_srcq[i]  = src[i];
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] ep;
        if (chk_en) begin
            for (int i = 0; i < N; i++)
                ep[i] = rst ? 1'b0 : (edge_en[i] ? m_pedge[i] : src[i]);
            check("int_o", 32'(int_o), 32'(m_int));
            check("int_id", 32'(int_id), 32'(m_id));
            check("mcause", mcause, 32'(m_id));
            check("busy", 32'(busy), 32'(m_state == 2));
            check("pending", pending, ep);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; src = '0; claim = 1'b0; int_rst = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_int(input string nm);
        int k;
        k = 0;
        while (!int_o && k < 8) begin
            tick();
            k++;
        end
        check(nm, 32'(int_o), 32'd1);
    endtask

    int exp_ids[4] = '{2, 7, 30, 2};

    initial begin
        #1 rst = 1'b1;
        edge_en = '0; mie = '1; src = '1;
        tick();
        tick();
        chk_en = 1'b1;

        // Reset hold with every line asserted
        check("rst_int", 32'(int_o), 32'd0);
        check("rst_mcause", mcause, 32'd0);
        check("rst_pending", pending, 32'd0);
        rst = 1'b0;
        tick();
        check("rel_int", 32'(int_o), 32'd1);
        check("rel_id", 32'(int_id), 32'd0);

        // Edge latch independent of mie, then claim
        do_reset();
        edge_en = 32'h1 << 5; mie = '0;
        tick();
        src[5] = 1'b1;
        tick();
        src[5] = 1'b0;
        #1;
        check("edge_pend", 32'(pending[5]), 32'd1);
        check("edge_noint", 32'(int_o), 32'd0);
        mie[5] = 1'b1;
        tick();
        check("edge_int", 32'(int_o), 32'd1);
        check("edge_id", 32'(int_id), 32'd5);
        claim = 1'b1;
        tick();
        claim = 1'b0;
        check("claim_pend", 32'(pending[5]), 32'd0);
        check("claim_busy", 32'(busy), 32'd1);
        check("claim_mcause", mcause, 32'd5);
        int_rst = 1'b1;
        tick();
        int_rst = 1'b0;

        // Round-robin over level sources 2, 7, 30
        do_reset();
        edge_en = '0; mie = '1;
        src = (32'h1 << 2) | (32'h1 << 7) | (32'h1 << 30);
        for (int r = 0; r < 4; r++) begin
            wait_int($sformatf("rr_int%0d", r));
            check($sformatf("rr_id%0d", r), 32'(int_id), 32'(exp_ids[r]));
            claim = 1'b1;
            tick();
            claim = 1'b0;
            int_rst = 1'b1;
            tick();
            int_rst = 1'b0;
        end

        // Withdrawal of level source 9 while presented
        do_reset();
        src = (32'h1 << 9) | (32'h1 << 12);
        tick();
        check("wd_id9", 32'(int_id), 32'd9);
        src[9] = 1'b0;
        tick();
        check("wd_drop", 32'(int_o), 32'd0);
        tick();
        check("wd_int12", 32'(int_o), 32'd1);
        check("wd_id12", 32'(int_id), 32'd12);

        // Claim colliding with a new rise on the same edge source
        do_reset();
        edge_en = 32'h1 << 3;
        src[3] = 1'b1;
        tick();
        src[3] = 1'b0;
        tick();
        check("col_int", 32'(int_o), 32'd1);
        check("col_id", 32'(int_id), 32'd3);
        claim = 1'b1; src[3] = 1'b1;
        tick();
        claim = 1'b0; src[3] = 1'b0;
        #1;
        check("col_pend", 32'(pending[3]), 32'd1);
        int_rst = 1'b1;
        tick();
        int_rst = 1'b0;
        tick();
        check("col_reint", 32'(int_o), 32'd1);
        check("col_reid", 32'(int_id), 32'd3);

        // Asynchronous reset during service of source 17
        do_reset();
        edge_en = '0;
        src = (32'h1 << 17) | (32'h1 << 20);
        tick();
        claim = 1'b1;
        tick();
        claim = 1'b0;
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_id", 32'(int_id), 32'd17);
        #2 rst = 1'b1;
        #1;
        check("async_busy", 32'(busy), 32'd0);
        check("async_id", 32'(int_id), 32'd0);
        check("async_int", 32'(int_o), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("ptr_cleared", 32'(int_id), 32'd17);

        // Randomized traffic
        do_reset();
        edge_en = $urandom;
        mie = $urandom | $urandom;
        for (int c = 0; c < 3000; c++) begin
            src = src ^ ($urandom & $urandom & $urandom);
            claim = ($urandom_range(0, 3) == 0);
            int_rst = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 49) == 0) mie = $urandom | $urandom;
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0; claim = 1'b0; int_rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
